div3_serial: RTL
================

Name: div3_serial

Overview:
- Sequential divide-by-3 unit. Accepts a WIDTH-bit unsigned operand with a start pulse and computes the quotient and remainder one bit per clock, MSB first, using restoring division.
- Also reports a divisibility flag.
- It is the computing counterpart of the combinational divisibility checker: same operand domain, but it produces the quotient and remainder rather than only a flag.
- Sits behind a simple start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and quotient width in bits. Legal range is ≥2.

Ports:
- clk  input  1  clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin a division; sampled only in IDLE
- din  input  WIDTH  unsigned dividend; sampled on the accepting edge
- busy  output  1  high while a division is in progress (RUN state)
- done  output  1  one-cycle pulse; results valid and updated
- quotient  output  WIDTH  floor(din/3) of the last completed operation
- remainder  output  2  din mod 3 of the last completed operation; values 0..2 only
- divisible  output  1  1 when the last completed remainder is 0

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. busy=0, done=0, quotient=0, remainder=0, divisible=0. Internal shift register, partial remainder and bit counter are cleared.
- Reset asserted mid-operation: the operation is aborted immediately with no done pulse. After reset deasserts, the block waits in IDLE for a new start.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch din into the shift register, clear partial remainder r (3-bit working value), load counter=WIDTH, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge processes one bit:
  - t = {r[1:0], msb of shift}.
  - If t ≥ 3: r = t−3 and q_bit=1; else r = t and q_bit=0.
  - Shift q_bit into the working quotient, shift operand left, decrement counter.
  - On the edge that processes the last bit (counter 1→0): write quotient/remainder/divisible output registers from the final values, go to DONE.
- DONE: done=1 for exactly this one cycle. Next edge returns to IDLE unconditionally.
- busy=1 exactly in RUN.
- Latency: start accepted at edge E0 → busy high for cycles E0..E(WIDTH) → done high in the cycle after edge E(WIDTH). Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored, not queued. din changes after the accepting edge have no effect.
- Output registers hold their value from one done pulse until the next done pulse or reset. Intermediate values are never visible on quotient/remainder.
- Arithmetic:
  - Partial remainder is always ≤2 before shifting, so t ≤ 5 fits in 3 bits.
  - quotient*3 + remainder == din for every operand.
  - Quotient never exceeds (2^WIDTH−1)/3.
- divisible == (remainder == 0), registered together with remainder.

Test Plan:
- Reset, then start with din=0 → done after 8 busy cycles; quotient=0, remainder=0, divisible=1.
- din=255 → quotient=85, remainder=0, divisible=1. Then din=200 → quotient=66, remainder=2, divisible=0. Then din=1 → quotient=0, remainder=1, divisible=0.
- Start with din=100; pulse start with din=9 while busy=1 → first result is quotient=33, remainder=1. The second start is ignored, no extra done. Start again in IDLE with 9 → quotient=3, remainder=0.
- Start with din=150; assert reset after 4 RUN cycles → all outputs 0 immediately, no done. Restart with din=7 → quotient=2, remainder=1.
- Hold start high continuously from reset → done pulses every 10 cycles; busy low only in the DONE and IDLE cycles between operations.
- Exhaustive sweep din=0..255 → for every operand quotient*3+remainder==din, remainder<3, and divisible==(din%3==0); the bench reports a pass/fail status at the end.

Source files
------------

// File: rtl/div3_serial.sv
// Serial restoring divide-by-3: one quotient bit per clock, MSB first.
// The operand shift register also collects the quotient bits as they are produced.
module div3_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [1:0]       remainder,
    output logic             divisible
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One restoring step: returns {quotient bit, new partial remainder}.
    function automatic logic [2:0] div3_step(input logic [2:0] t);
        logic [2:0] diff;
        diff = t - 3'd3;
        if (t >= 3'd3) begin
            div3_step = {1'b1, diff[1:0]};
        end else begin
            div3_step = {1'b0, t[1:0]};
        end
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [1:0]       rem_r, rem_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] quot_r, quot_s;
    logic [1:0]       remd_r, remd_s;
    logic             divis_r, divis_s;
    logic [2:0]       step_s;
    logic [WIDTH-1:0] shifted_s;

    // Next-state, datapath and output-register update logic.
    always_comb begin
        step_s    = div3_step({rem_r, shift_r[WIDTH-1]});
        shifted_s = {shift_r[WIDTH-2:0], step_s[2]};
        state_s   = state_r;
        shift_s   = shift_r;
        rem_s     = rem_r;
        cnt_s     = cnt_r;
        done_s    = 1'b0;
        quot_s    = quot_r;
        remd_s    = remd_r;
        divis_s   = divis_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    shift_s = din;
                    rem_s   = 2'd0;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_s = shifted_s;
                rem_s   = step_s[1:0];
                cnt_s   = cnt_r - CNT_ONE;
                // Last bit: publish results; outputs never show partial values.
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_DONE;
                    quot_s  = shifted_s;
                    remd_s  = step_s[1:0];
                    divis_s = (step_s[1:0] == 2'd0);
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_RUN);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            shift_r <= '0;
            rem_r   <= 2'd0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quot_r  <= '0;
            remd_r  <= 2'd0;
            divis_r <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            rem_r   <= rem_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            quot_r  <= quot_s;
            remd_r  <= remd_s;
            divis_r <= divis_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign remainder = remd_r;
    assign divisible = divis_r;

endmodule
